// File: rtl/data_bus_arbiter_pkg.sv
// Shared encodings for the MCU data bus arbiter: FSM states, access sizes,
// debug owner codes and the slave address map.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_OWN_M0 = 2'b01,
    ARB_OWN_M1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] BHW_BYTE = 2'b00;
  localparam logic [1:0] BHW_HALF = 2'b01;
  localparam logic [1:0] BHW_WORD = 2'b10;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  // Each slave region is 256 bytes; the decoder compares DAddr[31:8].
  localparam logic [31:0] RAM_BASE    = 32'h2000_0200;
  localparam logic [31:0] GPO_BASE    = 32'h4000_0000;
  localparam logic [31:0] GPI_BASE    = 32'h4000_0100;
  localparam logic [31:0] GPIO_BASE   = 32'h4000_0200;
  localparam logic [31:0] REGION_MASK = 32'hFFFF_FF00;

  function automatic logic [1:0] owner_of(input arb_state_t s);
    case (s)
      ARB_OWN_M0: owner_of = OWNER_M0;
      ARB_OWN_M1: owner_of = OWNER_M1;
      default:    owner_of = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the master that did not own the bus
// last wins. last = 0 means M0 owned last, 1 means M1.
module data_bus_arbiter_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant0,
  output logic grant1
);

  assign grant0 = req0 & (~req1 | last);
  assign grant1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the MCU data bus between the core (M0) and the DMA (M1) with bounded
// bursts, round-robin handover and error acks for unmapped addresses.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic [1:0]    m0_bhw,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  input  logic [1:0]    m1_bhw,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] DAddr,
  output logic [DW-1:0] DWrData,
  output logic          DWe,
  output logic [1:0]    BHW,
  input  logic [DW-1:0] DRdData,
  input  logic          dec_hit,
  output logic [1:0]    owner
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          last;
  logic          last_nxt;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    owner_q;

  logic own0;
  logic own1;
  logic act0;
  logic act1;
  logic req_own;
  logic lock_own;
  logic release_bus;
  logic pick_last;
  logic grant0;
  logic grant1;

  assign own0 = (state == ARB_OWN_M0);
  assign own1 = (state == ARB_OWN_M1);
  // Reset gates the access in the same cycle so no partial write escapes.
  assign act0 = own0 & m0_req & ~reset;
  assign act1 = own1 & m1_req & ~reset;

  assign req_own     = own1 ? m1_req : m0_req;
  assign lock_own    = own1 ? m1_lock : m0_lock;
  assign release_bus = ~req_own | ~lock_own | (burst_cnt == CNT_LAST);
  // On handover the current owner becomes "last", so the other side wins ties.
  assign pick_last   = (state == ARB_IDLE) ? last : own1;

  data_bus_arbiter_rr_pick u_rr_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (pick_last),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = burst_cnt;
    case (state)
      ARB_IDLE: begin
        cnt_nxt = '0;
        if (grant0)      state_nxt = ARB_OWN_M0;
        else if (grant1) state_nxt = ARB_OWN_M1;
      end
      ARB_OWN_M0, ARB_OWN_M1: begin
        if (release_bus) begin
          last_nxt = own1;
          cnt_nxt  = '0;
          if (grant0)      state_nxt = ARB_OWN_M0;
          else if (grant1) state_nxt = ARB_OWN_M1;
          else             state_nxt = ARB_IDLE;
        end else begin
          cnt_nxt = burst_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      owner_q   <= OWNER_NONE;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= cnt_nxt;
      owner_q   <= owner_of(state_nxt);
    end
  end

  assign owner = owner_q;

  // Bus mux: only an active owner drives the bus; everything else reads as 0.
  always_comb begin
    DAddr    = '0;
    DWrData  = '0;
    DWe      = 1'b0;
    BHW      = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    if (act0) begin
      DAddr   = m0_addr;
      DWrData = m0_wdata;
      BHW     = m0_bhw;
      DWe     = m0_we & dec_hit;
      m0_ack  = 1'b1;
      m0_err  = ~dec_hit;
      if (~m0_we & dec_hit) m0_rdata = DRdData;
    end else if (act1) begin
      DAddr   = m1_addr;
      DWrData = m1_wdata;
      BHW     = m1_bhw;
      DWe     = m1_we & dec_hit;
      m1_ack  = 1'b1;
      m1_err  = ~dec_hit;
      if (~m1_we & dec_hit) m1_rdata = DRdData;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a small RAM/IO slave model behind
// the bus and hand-computed expected acks, owners and read data.
module tb_data_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [1:0]  m0_bhw;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_lock, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [1:0]  m1_bhw;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] DAddr, DWrData, DRdData;
  logic        DWe;
  logic [1:0]  BHW;
  logic        dec_hit;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_errors = 0;

  data_bus_arbiter #(.MAX_BURST(8), .AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_lock  (m0_lock),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_we    (m0_we),
    .m0_bhw   (m0_bhw),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_lock  (m1_lock),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_we    (m1_we),
    .m1_bhw   (m1_bhw),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .m1_rdata (m1_rdata),
    .DAddr    (DAddr),
    .DWrData  (DWrData),
    .DWe      (DWe),
    .BHW      (BHW),
    .DRdData  (DRdData),
    .dec_hit  (dec_hit),
    .owner    (owner)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: 64-word RAM at 0x2000_02xx, IO regions read as 0,
  // unmapped reads return a floating-bus pattern.
  logic [31:0] ram [64];
  logic        ram_hit, io_hit;

  always_comb begin
    ram_hit = (DAddr[31:8] == 24'h200002);
    io_hit  = (DAddr[31:8] == 24'h400000) || (DAddr[31:8] == 24'h400001) ||
              (DAddr[31:8] == 24'h400002);
    dec_hit = ram_hit | io_hit;
    if (ram_hit)     DRdData = ram[DAddr[7:2]];
    else if (io_hit) DRdData = 32'h0;
    else             DRdData = 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (DWe && ram_hit) ram[DAddr[7:2]] = DWrData;
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_reqs();
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0;
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
  endtask

  task automatic go_idle();
    cyc();
    clear_reqs();
    cyc();
    cyc();
  endtask

  task automatic pulse_reset();
    clear_reqs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  int n0, n1;
  logic exp0, exp1;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[1] = 32'hC0DE_0001;
    reset = 1'b1;
    clear_reqs();
    m0_addr = '0; m0_wdata = '0; m0_bhw = 2'b10;
    m1_addr = '0; m1_wdata = '0; m1_bhw = 2'b10;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check("rst_owner", 32'(owner), 0);
    check("rst_m0_ack", 32'(m0_ack), 0);
    check("rst_m1_ack", 32'(m1_ack), 0);
    check("rst_dwe", 32'(DWe), 0);
    check("rst_daddr", DAddr, 0);

    // Solo M0: write then read back
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h2000_0200; m0_wdata = 32'hDEAD_BEEF;
    #1;
    check("solo_wr_idle_ack", 32'(m0_ack), 0);
    cyc(); #1;
    check("solo_wr_ack", 32'(m0_ack), 1);
    check("solo_wr_err", 32'(m0_err), 0);
    check("solo_wr_owner", 32'(owner), 1);
    check("solo_wr_dwe", 32'(DWe), 1);
    check("solo_wr_daddr", DAddr, 32'h2000_0200);
    check("solo_wr_wdata", DWrData, 32'hDEAD_BEEF);
    check("solo_wr_bhw", 32'(BHW), 2);
    cyc();
    m0_req = 1'b0; m0_we = 1'b0;
    #1;
    check("solo_gap_ack", 32'(m0_ack), 0);
    check("solo_ram0", ram[0], 32'hDEAD_BEEF);
    cyc();
    m0_req = 1'b1;
    #1;
    check("solo_rd_idle_ack", 32'(m0_ack), 0);
    cyc(); #1;
    check("solo_rd_ack", 32'(m0_ack), 1);
    check("solo_rd_data", m0_rdata, 32'hDEAD_BEEF);
    check("solo_rd_owner", 32'(owner), 1);
    check("solo_rd_dwe", 32'(DWe), 0);
    go_idle();

    // Tie from reset: M0 first, then alternate each cycle
    pulse_reset();
    m0_req = 1'b1; m0_addr = 32'h2000_0200;
    m1_req = 1'b1; m1_addr = 32'h2000_0204;
    #1;
    check("tie_idle_acks", 32'({m0_ack, m1_ack}), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      exp0 = (k % 2 == 0);
      check("tie_m0_ack", 32'(m0_ack), 32'(exp0));
      check("tie_m1_ack", 32'(m1_ack), 32'(!exp0));
      check("tie_owner", 32'(owner), exp0 ? 32'd1 : 32'd2);
      if (exp0) check("tie_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      else      check("tie_m1_rdata", m1_rdata, 32'hC0DE_0001);
    end
    go_idle();

    // Burst cap: M1 locks 20 writes, M0 requests from cycle 2
    n0 = 0; n1 = 0;
    m0_we = 1'b0; m0_addr = 32'h2000_0200;
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1;
    m1_addr = 32'h2000_0240; m1_wdata = 32'hA5A5_0000;
    #1;
    for (int t = 1; t <= 24; t++) begin
      cyc();
      m1_req   = (n1 < 20);
      m1_addr  = 32'h2000_0240 + 32'(n1 * 4);
      m1_wdata = 32'hA5A5_0000 + 32'(n1);
      m0_req   = (t >= 2) && (n0 == 0);
      #1;
      exp1 = ((t >= 1) && (t <= 8)) || ((t >= 10) && (t <= 21));
      exp0 = (t == 9);
      check("burst_m1_ack", 32'(m1_ack), 32'(exp1));
      check("burst_m0_ack", 32'(m0_ack), 32'(exp0));
      if (t == 9) check("burst_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      if (m1_ack) n1++;
      if (m0_ack) n0++;
    end
    check("burst_m1_total", 32'(n1), 20);
    check("burst_m0_total", 32'(n0), 1);
    check("burst_ram_first", ram[16], 32'hA5A5_0000);
    check("burst_ram_last", ram[35], 32'hA5A5_0013);
    go_idle();

    // Unmapped write and read
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h5000_0000; m0_wdata = 32'h1234_5678;
    cyc(); #1;
    check("unmap_wr_ack", 32'(m0_ack), 1);
    check("unmap_wr_err", 32'(m0_err), 1);
    check("unmap_wr_dwe", 32'(DWe), 0);
    cyc();
    m0_we = 1'b0;
    #1;
    check("unmap_rd_ack", 32'(m0_ack), 1);
    check("unmap_rd_err", 32'(m0_err), 1);
    check("unmap_rd_data", m0_rdata, 32'h0);
    check("unmap_ram0", ram[0], 32'hDEAD_BEEF);
    go_idle();

    // Reset asserted during the 3rd M1 write
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1;
    m1_addr = 32'h2000_02C0; m1_wdata = 32'h7700_0000;
    cyc(); #1;
    check("rstb_ack1", 32'(m1_ack), 1);
    cyc();
    m1_addr = 32'h2000_02C4; m1_wdata = 32'h7700_0001;
    #1;
    check("rstb_ack2", 32'(m1_ack), 1);
    cyc();
    m1_addr = 32'h2000_02C8; m1_wdata = 32'h7700_0002;
    reset = 1'b1;
    #1;
    check("rstb_mid_dwe", 32'(DWe), 0);
    check("rstb_mid_ack", 32'(m1_ack), 0);
    cyc();
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h2000_0200;
    #1;
    check("rstb_owner", 32'(owner), 0);
    check("rstb_acks", 32'({m0_ack, m1_ack}), 0);
    check("rstb_dwe", 32'(DWe), 0);
    check("rstb_daddr", DAddr, 0);
    check("rstb_ram_2nd", ram[49], 32'h7700_0001);
    check("rstb_ram_3rd", ram[50], 32'h0);
    cyc(); #1;
    check("rstb_tie_m0_ack", 32'(m0_ack), 1);
    check("rstb_tie_m1_ack", 32'(m1_ack), 0);
    check("rstb_tie_owner", 32'(owner), 1);
    go_idle();

    // Withdraw: locked M0 drops req, pending M1 takes over with no idle cycle
    m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 32'h2000_0200;
    cyc();
    m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 32'h2000_0204;
    #1;
    check("wd_m0_ack", 32'(m0_ack), 1);
    cyc();
    m0_req = 1'b0;
    #1;
    check("wd_no_ack", 32'({m0_ack, m1_ack}), 0);
    check("wd_no_bus", DAddr, 0);
    check("wd_owner_m0", 32'(owner), 1);
    cyc(); #1;
    check("wd_owner_m1", 32'(owner), 2);
    check("wd_m1_ack", 32'(m1_ack), 1);
    check("wd_m1_rdata", m1_rdata, 32'hC0DE_0001);
    go_idle();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
